// File: rtl/fir_param_dbuf.sv
// rtl/fir_param_dbuf.sv - pipelined FIR with double-buffered runtime coefficients
// Registered binary adder tree; valid bit travels beside the data through every stage.
module fir_param_dbuf #(
  parameter int NTAPS = 16,
  parameter int LOG2N = 4,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [LOG2N-1:0]     coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  input  logic                 round_en,
  input  logic                 sat_clr,
  output logic                 out_valid,
  output logic signed [DW-1:0] y_out,
  output logic                 sat_flag,
  output logic                 sat_sticky
);

  localparam int ACCW = DW + CW + LOG2N;
  localparam logic signed [ACCW:0] RNDV = {{ACCW{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACCW:0] MAXV = {{(ACCW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = {{(ACCW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] YMIN = {1'b1, {(DW - 1){1'b0}}};

  logic signed [DW-1:0]   x_r;
  logic                   v_r;
  logic signed [DW-1:0]   dl [NTAPS];
  logic                   dl_v;
  logic signed [CW-1:0]   shadow [NTAPS];
  logic signed [CW-1:0]   act [NTAPS];
  // Heap-ordered tree: leaves NTAPS..2*NTAPS-1 hold products, node 1 is the accumulator.
  logic signed [ACCW-1:0] node [1:2*NTAPS-1];
  logic [LOG2N:0]         tv;

  logic signed [ACCW:0]   sum_c;
  logic signed [ACCW:0]   s_c;
  logic                   sat_hi;
  logic                   sat_lo;

  always_comb begin
    sum_c  = {node[1][ACCW-1], node[1]} + (round_en ? RNDV : '0);
    s_c    = sum_c >>> SHIFT;
    sat_hi = s_c > MAXV;
    sat_lo = s_c < MINV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r        <= '0;
      v_r        <= 1'b0;
      dl_v       <= 1'b0;
      tv         <= '0;
      out_valid  <= 1'b0;
      y_out      <= '0;
      sat_flag   <= 1'b0;
      sat_sticky <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dl[i]     <= '0;
        shadow[i] <= '0;
        act[i]    <= '0;
      end
      for (int i = 1; i < 2 * NTAPS; i++) node[i] <= '0;
    end else begin
      v_r <= in_valid;
      if (in_valid) x_r <= x_in;

      dl_v <= v_r;
      if (v_r) begin
        dl[0] <= x_r;
        for (int i = 1; i < NTAPS; i++) dl[i] <= dl[i-1];
      end

      // Leaves latch the active bank at this edge, so a token never mixes banks.
      tv <= {tv[LOG2N-1:0], dl_v};
      for (int i = 0; i < NTAPS; i++) node[NTAPS+i] <= ACCW'(dl[i]) * ACCW'(act[i]);
      for (int i = 1; i < NTAPS; i++) node[i] <= node[2*i] + node[2*i+1];

      if (coef_we) shadow[coef_addr] <= coef_data;
      if (coef_swap) begin
        for (int i = 0; i < NTAPS; i++)
          act[i] <= (coef_we && coef_addr == LOG2N'(i)) ? coef_data : shadow[i];
      end

      out_valid <= tv[LOG2N];
      if (tv[LOG2N]) begin
        y_out    <= sat_hi ? YMAX : (sat_lo ? YMIN : s_c[DW-1:0]);
        sat_flag <= sat_hi | sat_lo;
      end else begin
        sat_flag <= 1'b0;
      end
      sat_sticky <= (tv[LOG2N] & (sat_hi | sat_lo)) | (sat_sticky & ~sat_clr);
    end
  end

endmodule

// File: tb/tb_fir_param_dbuf.sv
// tb/tb_fir_param_dbuf.sv - scoreboard bench for fir_param_dbuf
// Sample-level reference model pushes expected outputs; a negedge monitor pops and compares.
module tb_fir_param_dbuf;

  localparam int NTAPS = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int SHIFT = 15;
  localparam int LAT   = LOG2N + 3;
  localparam longint YMAX = (longint'(1) << (DW - 1)) - 1;
  localparam longint YMIN = -(longint'(1) << (DW - 1));

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] x_in;
  logic                 coef_we;
  logic [LOG2N-1:0]     coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_swap;
  logic                 round_en;
  logic                 sat_clr;
  logic                 out_valid;
  logic signed [DW-1:0] y_out;
  logic                 sat_flag;
  logic                 sat_sticky;

  fir_param_dbuf #(.NTAPS(NTAPS), .LOG2N(LOG2N), .DW(DW), .CW(CW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .round_en(round_en), .sat_clr(sat_clr),
    .out_valid(out_valid), .y_out(y_out), .sat_flag(sat_flag), .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [DW-1:0] y;
    logic                 sat;
    int                   cyc;
  } exp_t;

  exp_t   sbq[$];
  exp_t   e;
  int     ncmp = 0;
  int     nerr = 0;
  logic signed [DW-1:0] last_y;
  longint mdl [NTAPS];
  longint msh [NTAPS];
  longint mact [NTAPS];
  logic   pend = 1'b0;
  int     pend_x;
  int     pend_cyc;
  logic   msticky = 1'b0;
  logic [6:0] gap_pat = 7'b1011001;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Model a sample one edge after acceptance, when its multiply bank is settled.
  task automatic model_sample();
    longint acc, s, ey;
    logic   es;
    for (int i = NTAPS - 1; i > 0; i--) mdl[i] = mdl[i-1];
    mdl[0] = pend_x;
    acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += mdl[i] * mact[i];
    if (round_en) acc += longint'(1) << (SHIFT - 1);
    s  = acc >>> SHIFT;
    es = (s > YMAX) || (s < YMIN);
    ey = (s > YMAX) ? YMAX : ((s < YMIN) ? YMIN : s);
    if (es) msticky = 1'b1;
    sbq.push_back('{y: DW'(ey), sat: es, cyc: pend_cyc});
  endtask

  task automatic step(input logic v, input int x);
    in_valid = v;
    x_in     = DW'(x);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend    = 1'b0;
      msticky = 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        mdl[i] = 0; msh[i] = 0; mact[i] = 0;
      end
    end else begin
      if (coef_we) msh[coef_addr] = coef_data;
      if (coef_swap) mact = msh;
      if (sat_clr) msticky = 1'b0;
      if (pend) model_sample();
      pend     = v;
      pend_x   = x;
      pend_cyc = cyc;
    end
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    sat_clr   = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic load(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = LOG2N'(a);
    coef_data = CW'(d);
    step(1'b0, 0);
  endtask

  task automatic swap();
    coef_swap = 1'b1;
    step(1'b0, 0);
  endtask

  task automatic drain();
    repeat (LAT + 4) step(1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      last_y = '0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        check("out_valid_extra", out_valid, 0);
      end else begin
        e = sbq.pop_front();
        check("y_out", y_out, e.y);
        check("sat_flag", sat_flag, e.sat);
        check("latency", cyc - e.cyc, LAT);
        last_y = e.y;
      end
    end else begin
      check("y_hold", y_out, last_y);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; coef_swap = 1'b0; round_en = 1'b0; sat_clr = 1'b0;

    repeat (3) begin
      step(1'b0, 0);
      check("rst_valid", out_valid, 0);
      check("rst_y", y_out, 0);
      check("rst_sticky", sat_sticky, 0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      step(1'b0, 0);
      check("idle_valid", out_valid, 0);
      check("idle_y", y_out, 0);
      check("idle_sticky", sat_sticky, 0);
    end

    // impulse response
    for (int i = 0; i < NTAPS; i++) load(i, 1000 * (i + 1));
    swap();
    step(1'b1, 16384);
    repeat (31) step(1'b1, 0);
    drain();

    // gapped input with the same impulse
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < 7; j++) step(gap_pat[6-j], (r == 0 && j == 0) ? 16384 : 0);
    drain();

    // positive then negative saturation, sticky and clear
    for (int i = 0; i < NTAPS; i++) load(i, 32767);
    swap();
    repeat (20) step(1'b1, 32767);
    drain();
    check("sticky_pos", sat_sticky, msticky);
    check("y_pos_sat", y_out, YMAX);
    sat_clr = 1'b1;
    step(1'b0, 0);
    check("sticky_clr1", sat_sticky, msticky);
    repeat (20) step(1'b1, -32768);
    drain();
    check("sticky_neg", sat_sticky, msticky);
    check("y_neg_sat", y_out, YMIN);
    sat_clr = 1'b1;
    step(1'b0, 0);
    check("sticky_clr2", sat_sticky, 0);

    // rounding
    load(0, 1);
    for (int i = 1; i < NTAPS; i++) load(i, 0);
    swap();
    round_en = 1'b0; step(1'b1, 16384);  drain(); check("rnd_pos_trunc", y_out, 0);
    round_en = 1'b1; step(1'b1, 16384);  drain(); check("rnd_pos_round", y_out, 1);
    round_en = 1'b0; step(1'b1, -16384); drain(); check("rnd_neg_trunc", y_out, -1);
    round_en = 1'b1; step(1'b1, -16384); drain(); check("rnd_neg_round", y_out, 0);
    round_en = 1'b0;

    // live swap with shadow writes during streaming
    for (int i = 0; i < NTAPS; i++) load(i, 1000);
    swap();
    repeat (20) step(1'b1, 16384);
    for (int i = 0; i < NTAPS; i++) begin
      coef_we = 1'b1; coef_addr = LOG2N'(i); coef_data = CW'(2000);
      step(1'b1, 16384);
    end
    check("steady_a", y_out, 8000);
    coef_swap = 1'b1;
    step(1'b1, 16384);
    repeat (20) step(1'b1, 16384);
    check("steady_b", y_out, 16000);
    coef_we = 1'b1; coef_addr = '0; coef_data = CW'(5000); coef_swap = 1'b1;
    step(1'b1, 16384);
    repeat (20) step(1'b1, 16384);
    drain();
    check("steady_c", y_out, 17500);

    // reset mid-stream discards in-flight samples
    repeat (3) step(1'b1, 16384);
    rst_n = 1'b0;
    step(1'b0, 0);
    step(1'b0, 0);
    rst_n = 1'b1;
    repeat (12) begin
      step(1'b0, 0);
      check("post_rst_valid", out_valid, 0);
    end
    check("post_rst_y", y_out, 0);

    check("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
